bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master, three-slave arbiter for the serial system bus. It grants bus ownership to one master at a time using round-robin priority, latches the target slave, and drives the one-hot slave enables that gate the serial address/data/burst lines into the slave input ports. A hold-limit timer forcibly releases a master that keeps ownership too long.

## Interface
- HOLD_LIMIT, 1024: maximum granted tenure in clk cycles; legal range 1..4095.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- m1_req  in  1  master 1 requests the bus; held high for the whole transaction.
- m1_slave_sel  in  2  master 1 target slave: 0, 1, 2; 3 is invalid.
- m2_req  in  1  master 2 request.
- m2_slave_sel  in  2  master 2 target slave.
- m1_grant  out  1  master 1 owns the bus.
- m2_grant  out  1  master 2 owns the bus.
- m_sel  out  1  current owner for the external line mux: 0 = m1, 1 = m2; holds its last value when idle.
- slave_sel  out  2  latched target slave; valid while bus_busy.
- s_en  out  3  one-hot slave enable, equal to 1 << slave_sel while granted, else 0.
- bus_busy  out  1  m1_grant | m2_grant.
- timeout  out  1  one-cycle pulse on a forced release.

## Operation
- States: IDLE, GRANT_M1, GRANT_M2, RELEASE. All outputs are registered.
- Reset values: state IDLE, all grants 0, s_en 0, bus_busy 0, timeout 0, m_sel 0, slave_sel 0, hold counter 0, last_master 1 (so m1 wins the first contention).
- A request is eligible when mX_req = 1 and mX_slave_sel != 3. An ineligible request is never granted and produces no other response.
- **IDLE**
  - Only one master eligible: go to GRANT_Mx.
  - Both eligible: grant the master that is not last_master.
  - Entering GRANT_Mx: latch slave_sel from mX_slave_sel, set m_sel, set last_master = x, clear the hold counter.
  - No eligible master: stay in IDLE.
- **GRANT_Mx**
  - slave_sel stays frozen even if mX_slave_sel changes.
  - mX_req = 0: go to RELEASE.
  - Otherwise, hold counter == HOLD_LIMIT-1: go to RELEASE and pulse timeout.
  - Otherwise: increment the hold counter.
  - The other master's request has no effect until RELEASE completes.
- **RELEASE**
  - All grants and s_en are 0.
  - Go to IDLE unconditionally. This one-cycle gap lets the slave ports return to idle before the lines change source.
- Hold counter is 12 bits unsigned and never wraps, because HOLD_LIMIT ≤ 4095.
- A request that stays high after a timeout is treated as a new request in IDLE and competes under round-robin; the other master wins if it is eligible.

## Timing
- Grant latency: req sampled high in IDLE at edge N; grant and s_en are high after edge N.
- Release latency: req sampled low at edge N in GRANT; grant drops after edge N; RELEASE occupies one cycle; IDLE after edge N+1.
- Earliest next grant: after edge N+2, giving a minimum of 2 dead cycles between owners.
- Maximum tenure: exactly HOLD_LIMIT cycles with grant high. timeout is high for the single cycle in which grant first reads 0.
- m_sel, slave_sel and s_en change only on the edge that asserts grant. They never change while a grant is high.
- Reset asserted mid-tenure: grants and s_en drop asynchronously, with no timeout pulse. After reset deassertion the FSM starts in IDLE with m1 priority.

## Test plan
- **Single grant:** reset; m1_req = 1, m1_slave_sel = 2 -> m1_grant = 1, s_en = 3'b100, m_sel = 0 one cycle later; drop req -> grant 0 next cycle, bus_busy 0 for 2 cycles.
- **Round-robin:** both req high from reset with sel 0/1 -> m1 granted first (s_en = 001). Release m1 and keep m2_req high -> m2 granted 2 cycles after m1's drop (s_en = 010). Both request again -> m1 granted.
- **Timeout:** HOLD_LIMIT = 8, m2_req held high -> m2_grant high exactly 8 cycles, timeout pulses once. With m1_req also high, m1 is granted next.
- **Invalid target:** m1_slave_sel = 3 with req high for 20 cycles -> no grant, s_en = 0. Changing sel to 1 -> grant next cycle with s_en = 010.
- **Frozen select:** m1 granted with sel 0, then change sel to 2 mid-tenure -> slave_sel stays 0 until release.
- **Reset mid-tenure:** reset low while m2 is granted -> all outputs at reset values immediately. After release, both requesting -> m1 wins.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, three-slave arbiter for the serial system bus.
// One master at a time owns the bus under round-robin priority. The owner's
// target slave is latched on the grant edge and drives a one-hot slave enable.
// A hold-limit timer forcibly releases an owner that keeps the bus too long,
// and every ownership change passes through a one-cycle RELEASE gap so the
// slave ports return to idle before the serial lines change source.
//
// Handshake: a master raises mX_req with a valid mX_slave_sel (0..2) and holds
// req high for the whole transaction; mX_grant high means it owns the bus.
// Dropping req ends the tenure. The request is sampled on the rising edge.
module bus_arbiter #(
  parameter int HOLD_LIMIT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_req,
  input  logic [1:0] m1_slave_sel,
  input  logic       m2_req,
  input  logic [1:0] m2_slave_sel,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       m_sel,
  output logic [1:0] slave_sel,
  output logic [2:0] s_en,
  output logic       bus_busy,
  output logic       timeout,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M1 = 2'd1,
    GRANT_M2 = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Last count value before a forced release; HOLD_LIMIT is at most 4095,
  // so the 12-bit hold counter never wraps.
  localparam logic [11:0] HOLD_LAST = 12'(HOLD_LIMIT - 1);

  state_e      state_q,       state_d;
  logic        m1_grant_q,    m1_grant_d;
  logic        m2_grant_q,    m2_grant_d;
  logic        m_sel_q,       m_sel_d;
  logic [1:0]  slave_sel_q,   slave_sel_d;
  logic [2:0]  s_en_q,        s_en_d;
  logic        bus_busy_q,    bus_busy_d;
  logic        timeout_q,     timeout_d;
  logic [11:0] hold_cnt_q,    hold_cnt_d;
  // 1 when m2 was the most recent owner; reset to 1 so m1 wins first contention.
  logic        last_m2_q,     last_m2_d;

  logic        m1_elig;
  logic        m2_elig;

  // A request whose target is 3 is ignored entirely.
  assign m1_elig = m1_req && (m1_slave_sel != 2'd3);
  assign m2_elig = m2_req && (m2_slave_sel != 2'd3);

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      m1_grant_q  <= 1'b0;
      m2_grant_q  <= 1'b0;
      m_sel_q     <= 1'b0;
      slave_sel_q <= 2'd0;
      s_en_q      <= 3'd0;
      bus_busy_q  <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= 12'd0;
      last_m2_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      m1_grant_q  <= m1_grant_d;
      m2_grant_q  <= m2_grant_d;
      m_sel_q     <= m_sel_d;
      slave_sel_q <= slave_sel_d;
      s_en_q      <= s_en_d;
      bus_busy_q  <= bus_busy_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
      last_m2_q   <= last_m2_d;
    end
  end

  // Next-state and next-output logic; m_sel/slave_sel/s_en only move on a grant edge.
  always_comb begin
    state_d     = state_q;
    m1_grant_d  = m1_grant_q;
    m2_grant_d  = m2_grant_q;
    m_sel_d     = m_sel_q;
    slave_sel_d = slave_sel_q;
    s_en_d      = s_en_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    last_m2_d   = last_m2_q;

    case (state_q)
      IDLE: begin
        m1_grant_d = 1'b0;
        m2_grant_d = 1'b0;
        s_en_d     = 3'd0;
        // m1 wins unless m2 is also eligible and m1 owned the bus last.
        if (m1_elig && (!m2_elig || last_m2_q)) begin
          state_d     = GRANT_M1;
          m1_grant_d  = 1'b1;
          m_sel_d     = 1'b0;
          slave_sel_d = m1_slave_sel;
          s_en_d      = 3'b001 << m1_slave_sel;
          last_m2_d   = 1'b0;
          hold_cnt_d  = 12'd0;
        end else if (m2_elig) begin
          state_d     = GRANT_M2;
          m2_grant_d  = 1'b1;
          m_sel_d     = 1'b1;
          slave_sel_d = m2_slave_sel;
          s_en_d      = 3'b001 << m2_slave_sel;
          last_m2_d   = 1'b1;
          hold_cnt_d  = 12'd0;
        end
      end

      GRANT_M1: begin
        if (!m1_req) begin
          state_d    = RELEASE;
          m1_grant_d = 1'b0;
          s_en_d     = 3'd0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RELEASE;
          m1_grant_d = 1'b0;
          s_en_d     = 3'd0;
          timeout_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 12'd1;
        end
      end

      GRANT_M2: begin
        if (!m2_req) begin
          state_d    = RELEASE;
          m2_grant_d = 1'b0;
          s_en_d     = 3'd0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RELEASE;
          m2_grant_d = 1'b0;
          s_en_d     = 3'd0;
          timeout_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 12'd1;
        end
      end

      RELEASE: begin
        // Dead cycle: nobody drives the slave ports, then back to arbitration.
        state_d    = IDLE;
        m1_grant_d = 1'b0;
        m2_grant_d = 1'b0;
        s_en_d     = 3'd0;
      end

      default: begin
        state_d    = IDLE;
        m1_grant_d = 1'b0;
        m2_grant_d = 1'b0;
        s_en_d     = 3'd0;
      end
    endcase

    bus_busy_d = m1_grant_d | m2_grant_d;
  end

  assign m1_grant  = m1_grant_q;
  assign m2_grant  = m2_grant_q;
  assign m_sel     = m_sel_q;
  assign slave_sel = slave_sel_q;
  assign s_en      = s_en_q;
  assign bus_busy  = bus_busy_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vector table, hand-written async-reset sequence and
// randomized traffic against a behavioural ownership model for bus_arbiter.
module tb_bus_arbiter;

  localparam int HL = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       m1_req = 1'b0;
  logic [1:0] m1_slave_sel = 2'd0;
  logic       m2_req = 1'b0;
  logic [1:0] m2_slave_sel = 2'd0;
  logic       m1_grant, m2_grant, m_sel, bus_busy, timeout;
  logic [1:0] slave_sel, dbg_state;
  logic [2:0] s_en;

  always #5 clk = ~clk;

  bus_arbiter #(.HOLD_LIMIT(HL)) dut (
    .clk          (clk),
    .reset        (reset),
    .m1_req       (m1_req),
    .m1_slave_sel (m1_slave_sel),
    .m2_req       (m2_req),
    .m2_slave_sel (m2_slave_sel),
    .m1_grant     (m1_grant),
    .m2_grant     (m2_grant),
    .m_sel        (m_sel),
    .slave_sel    (slave_sel),
    .s_en         (s_en),
    .bus_busy     (bus_busy),
    .timeout      (timeout),
    .dbg_state    (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // {m1_grant, m2_grant, m_sel, slave_sel, s_en, bus_busy, timeout}
  function automatic logic [9:0] pack(input logic g1, input logic g2, input logic ms,
                                      input logic [1:0] ss, input logic [2:0] se,
                                      input logic to);
    return {g1, g2, ms, ss, se, g1 | g2, to};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {m1_grant, m2_grant, m_sel, slave_sel, s_en, bus_busy, timeout};
  endfunction

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] got;
    got = dut_vec();
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got g1g2_ms_ss_sen_busy_to=%b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r1, input logic [1:0] s1, input logic r2, input logic [1:0] s2);
    m1_req = r1; m1_slave_sel = s1; m2_req = r2; m2_slave_sel = s2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst_before;
    logic       r1;
    logic [1:0] s1;
    logic       r2;
    logic [1:0] s2;
    int         reps;
    logic       g1, g2, msel;
    logic [1:0] ssel;
    logic [2:0] sen;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rb, input logic r1, input logic [1:0] s1,
                              input logic r2, input logic [1:0] s2, input int reps,
                              input logic g1, input logic g2, input logic msel,
                              input logic [1:0] ssel, input logic [2:0] sen, input logic to);
    vec_t v;
    v.rst_before = rb; v.r1 = r1; v.s1 = s1; v.r2 = r2; v.s2 = s2; v.reps = reps;
    v.g1 = g1; v.g2 = g2; v.msel = msel; v.ssel = ssel; v.sen = sen; v.to = to;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Ownership view: who owns the bus, how many cycles it has held it, whether
  // the mandatory dead cycle is pending, and who owned it last.
  int         m_own;   // 0 none, 1 m1, 2 m2
  int         m_ten;
  int         m_last;
  bit         m_gap;
  logic       m_msel;
  logic [1:0] m_ssel;
  logic       m_to;

  task automatic model_reset();
    m_own = 0; m_ten = 0; m_last = 2; m_gap = 0; m_msel = 0; m_ssel = 0; m_to = 0;
  endtask

  task automatic model_step(input logic r1, input logic [1:0] s1, input logic r2, input logic [1:0] s2);
    bit e1, e2, rq;
    int pick;
    m_to = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_own != 0) begin
      rq = (m_own == 1) ? r1 : r2;
      if (!rq || m_ten == HL) begin
        m_to  = rq && (m_ten == HL);
        m_own = 0;
        m_gap = 1;
      end else begin
        m_ten++;
      end
    end else begin
      e1 = r1 && (s1 != 2'd3);
      e2 = r2 && (s2 != 2'd3);
      if (e1 && e2) pick = (m_last == 1) ? 2 : 1;
      else if (e1)  pick = 1;
      else if (e2)  pick = 2;
      else          pick = 0;
      if (pick != 0) begin
        m_own  = pick;
        m_ten  = 1;
        m_last = pick;
        m_msel = (pick == 2);
        m_ssel = (pick == 1) ? s1 : s2;
      end
    end
  endtask

  function automatic logic [9:0] model_vec();
    logic [2:0] se;
    se = (m_own != 0) ? (3'b001 << m_ssel) : 3'b000;
    return pack(m_own == 1, m_own == 2, m_msel, m_ssel, se, m_to);
  endfunction

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];

  // ---------------- test ----------------
  initial begin
    // single grant / release with two dead cycles
    tbl.push_back(mk(1, 1,2, 0,0, 2,  1,0,0, 2,3'b100, 0));
    tbl.push_back(mk(0, 0,2, 0,0, 2,  0,0,0, 2,3'b000, 0));
    // round-robin
    tbl.push_back(mk(1, 1,0, 1,1, 1,  1,0,0, 0,3'b001, 0));
    tbl.push_back(mk(0, 0,0, 1,1, 2,  0,0,0, 0,3'b000, 0));
    tbl.push_back(mk(0, 0,0, 1,1, 1,  0,1,1, 1,3'b010, 0));
    tbl.push_back(mk(0, 0,0, 0,1, 1,  0,0,1, 1,3'b000, 0));
    tbl.push_back(mk(0, 1,0, 1,1, 1,  0,0,1, 1,3'b000, 0));
    tbl.push_back(mk(0, 1,0, 1,1, 1,  1,0,0, 0,3'b001, 0));
    // hold-limit timeout, then the waiting master takes over
    tbl.push_back(mk(1, 0,0, 1,2, 1,  0,1,1, 2,3'b100, 0));
    tbl.push_back(mk(0, 1,1, 1,2, 7,  0,1,1, 2,3'b100, 0));
    tbl.push_back(mk(0, 1,1, 1,2, 1,  0,0,1, 2,3'b000, 1));
    tbl.push_back(mk(0, 1,1, 1,2, 1,  0,0,1, 2,3'b000, 0));
    tbl.push_back(mk(0, 1,1, 1,2, 1,  1,0,0, 1,3'b010, 0));
    tbl.push_back(mk(0, 0,1, 1,2, 2,  0,0,0, 1,3'b000, 0));
    tbl.push_back(mk(0, 0,1, 1,2, 1,  0,1,1, 2,3'b100, 0));
    // invalid target ignored, then granted once valid
    tbl.push_back(mk(1, 1,3, 0,0, 20, 0,0,0, 0,3'b000, 0));
    tbl.push_back(mk(0, 1,1, 0,0, 1,  1,0,0, 1,3'b010, 0));
    // frozen slave select during tenure
    tbl.push_back(mk(1, 1,0, 0,0, 1,  1,0,0, 0,3'b001, 0));
    tbl.push_back(mk(0, 1,2, 0,0, 3,  1,0,0, 0,3'b001, 0));
    tbl.push_back(mk(0, 0,2, 0,0, 1,  0,0,0, 0,3'b000, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_reset();
      for (int r = 0; r < tbl[i].reps; r++) begin
        drive(tbl[i].r1, tbl[i].s1, tbl[i].r2, tbl[i].s2);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d.%0d", i, r),
              pack(tbl[i].g1, tbl[i].g2, tbl[i].msel, tbl[i].ssel, tbl[i].sen, tbl[i].to));
      end
    end

    // reset values, then asynchronous reset in the middle of an m2 tenure
    do_reset();
    check("reset_vals", pack(0, 0, 0, 2'd0, 3'd0, 0));
    drive(1'b0, 2'd0, 1'b1, 2'd1);
    @(posedge clk);
    @(negedge clk);
    check("m2_before_reset", pack(0, 1, 1, 2'd1, 3'b010, 0));
    #2 reset = 1'b0;
    #1 check("async_reset", pack(0, 0, 0, 2'd0, 3'd0, 0));
    drive(1'b1, 2'd0, 1'b1, 2'd1);
    @(negedge clk);
    check("held_in_reset", pack(0, 0, 0, 2'd0, 3'd0, 0));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("m1_after_reset", pack(1, 0, 0, 2'd0, 3'b001, 0));

    // randomized traffic against the model
    do_reset();
    model_reset();
    exp_q.delete();
    begin
      logic       r1, r2;
      logic [1:0] s1, s2;
      r1 = 0; r2 = 0; s1 = 0; s2 = 0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 7) == 0) r1 = ~r1;
        if ($urandom_range(0, 7) == 0) r2 = ~r2;
        if ($urandom_range(0, 3) == 0) s1 = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) s2 = 2'($urandom_range(0, 3));
        drive(r1, s1, r2, s2);
        @(posedge clk);
        model_step(r1, s1, r2, s2);
        exp_q.push_back(model_vec());
        @(negedge clk);
        check($sformatf("rand%0d", c), exp_q.pop_front());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
